// File: rtl/gimbal_step_scheduler.sv
// gimbal_step_scheduler
// Turns the per-field tracking decision into step/dir/enable drive for the
// azimuth and elevation stepper axes. A frame supervisor latches the axis
// commands and tracks how long the target has been lost; one axis sequencer
// per motor times direction setup, the step pulse and the inter-step gap.

module gimbal_step_axis #(
  parameter int FAST_DIV  = 4000,
  parameter int SLOW_DIV  = 16000,
  parameter int PULSE_W   = 8,
  parameter int DIR_SETUP = 20,
  parameter int CNT_W     = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic cmd_active,
  input  logic cmd_dir,
  input  logic cmd_fast,
  input  logic en_req,
  output logic step,
  output logic dir,
  output logic en
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_PULSE = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  // Counter reload values; every load means "stay here for value+1 cycles".
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(DIR_SETUP - 1);
  localparam logic [CNT_W-1:0] FAST_GAP   = CNT_W'(FAST_DIV - PULSE_W - 1);
  localparam logic [CNT_W-1:0] SLOW_GAP   = CNT_W'(SLOW_DIV - PULSE_W - 1);

  logic [1:0]       state_r;
  logic [1:0]       state_s;
  logic [1:0]       go_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic [CNT_W-1:0] go_cnt_s;
  logic             dir_r;
  logic             dir_s;
  logic             go_dir_s;
  logic             step_r;
  logic             en_r;

  // Step decision shared by IDLE and the end of GAP: start a pulse, or
  // first move dir and wait out the setup time.
  always_comb begin
    go_state_s = ST_IDLE;
    go_cnt_s   = cnt_r;
    go_dir_s   = dir_r;
    if (cmd_active) begin
      if (cmd_dir != dir_r) begin
        go_state_s = ST_SETUP;
        go_cnt_s   = SETUP_LOAD;
        go_dir_s   = cmd_dir;
      end else begin
        go_state_s = ST_PULSE;
        go_cnt_s   = PULSE_LOAD;
      end
    end else begin
      go_state_s = ST_IDLE;
    end
  end

  // Axis sequencer next-state logic; PULSE and GAP always run to completion.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    dir_s   = dir_r;
    case (state_r)
      ST_IDLE: begin
        state_s = go_state_s;
        cnt_s   = go_cnt_s;
        dir_s   = go_dir_s;
      end
      ST_SETUP: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = ST_PULSE;
          cnt_s   = PULSE_LOAD;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      ST_PULSE: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = ST_GAP;
          cnt_s   = cmd_fast ? FAST_GAP : SLOW_GAP;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      ST_GAP: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = go_state_s;
          cnt_s   = go_cnt_s;
          dir_s   = go_dir_s;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // Sequencer registers; step is the registered PULSE state so it is glitch
  // free and lags the state by one cycle, and dir only moves on SETUP entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      dir_r   <= 1'b0;
      step_r  <= 1'b0;
      en_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      dir_r   <= dir_s;
      step_r  <= (state_r == ST_PULSE);
      en_r    <= en_req | (en_r & (state_s != ST_IDLE));
    end
  end

  assign step = step_r;
  assign dir  = dir_r;
  assign en   = en_r;

endmodule

module gimbal_step_scheduler #(
  parameter int FAST_DIV    = 4000,
  parameter int SLOW_DIV    = 16000,
  parameter int PULSE_W     = 8,
  parameter int DIR_SETUP   = 20,
  parameter int LOST_FRAMES = 4,
  parameter int CNT_W       = 16
) (
  input  logic clk4mhz,
  input  logic reset_n,
  input  logic frame_valid,
  input  logic target_valid,
  input  logic az_dir_in,
  input  logic el_dir_in,
  input  logic az_fast,
  input  logic el_fast,
  input  logic az_hold,
  input  logic el_hold,
  output logic az_step,
  output logic az_dir,
  output logic az_en,
  output logic el_step,
  output logic el_dir,
  output logic el_en,
  output logic tracking
);

  localparam int              LC_W     = $clog2(LOST_FRAMES + 1);
  localparam logic [LC_W-1:0] LOST_MAX = LC_W'(LOST_FRAMES);
  localparam logic [LC_W-1:0] LC_ZERO  = {LC_W{1'b0}};
  localparam logic [LC_W-1:0] LC_ONE   = LC_W'(1);

  logic [LC_W-1:0] lost_cnt_r;
  logic [LC_W-1:0] lost_s;
  logic            tracking_r;
  logic            trk_s;
  logic            az_act_r, az_act_s;
  logic            az_cdir_r, az_cdir_s;
  logic            az_cfast_r, az_cfast_s;
  logic            el_act_r, el_act_s;
  logic            el_cdir_r, el_cdir_s;
  logic            el_cfast_r, el_cfast_s;

  // Frame supervisor: latch commands on a target field, count missed fields
  // and drop tracking plus both axis commands once the count saturates.
  always_comb begin
    lost_s     = lost_cnt_r;
    trk_s      = tracking_r;
    az_act_s   = az_act_r;
    az_cdir_s  = az_cdir_r;
    az_cfast_s = az_cfast_r;
    el_act_s   = el_act_r;
    el_cdir_s  = el_cdir_r;
    el_cfast_s = el_cfast_r;
    if (frame_valid) begin
      if (target_valid) begin
        lost_s     = LC_ZERO;
        trk_s      = 1'b1;
        az_act_s   = ~az_hold;
        az_cdir_s  = az_dir_in;
        az_cfast_s = az_fast;
        el_act_s   = ~el_hold;
        el_cdir_s  = el_dir_in;
        el_cfast_s = el_fast;
      end else if (lost_cnt_r != LOST_MAX) begin
        lost_s = lost_cnt_r + LC_ONE;
        if ((lost_cnt_r + LC_ONE) == LOST_MAX) begin
          trk_s    = 1'b0;
          az_act_s = 1'b0;
          el_act_s = 1'b0;
        end else begin
          trk_s = tracking_r;
        end
      end else begin
        lost_s = LOST_MAX;
      end
    end else begin
      lost_s = lost_cnt_r;
    end
  end

  // Supervisor registers; reset starts the block in the lost state.
  always_ff @(posedge clk4mhz or negedge reset_n) begin
    if (!reset_n) begin
      lost_cnt_r <= LOST_MAX;
      tracking_r <= 1'b0;
      az_act_r   <= 1'b0;
      az_cdir_r  <= 1'b0;
      az_cfast_r <= 1'b0;
      el_act_r   <= 1'b0;
      el_cdir_r  <= 1'b0;
      el_cfast_r <= 1'b0;
    end else begin
      lost_cnt_r <= lost_s;
      tracking_r <= trk_s;
      az_act_r   <= az_act_s;
      az_cdir_r  <= az_cdir_s;
      az_cfast_r <= az_cfast_s;
      el_act_r   <= el_act_s;
      el_cdir_r  <= el_cdir_s;
      el_cfast_r <= el_cfast_s;
    end
  end

  assign tracking = tracking_r;

  // Enables follow the next tracking value so they rise on the same edge.
  gimbal_step_axis #(
    .FAST_DIV (FAST_DIV),
    .SLOW_DIV (SLOW_DIV),
    .PULSE_W  (PULSE_W),
    .DIR_SETUP(DIR_SETUP),
    .CNT_W    (CNT_W)
  ) u_az (
    .clk       (clk4mhz),
    .reset_n   (reset_n),
    .cmd_active(az_act_r),
    .cmd_dir   (az_cdir_r),
    .cmd_fast  (az_cfast_r),
    .en_req    (trk_s),
    .step      (az_step),
    .dir       (az_dir),
    .en        (az_en)
  );

  gimbal_step_axis #(
    .FAST_DIV (FAST_DIV),
    .SLOW_DIV (SLOW_DIV),
    .PULSE_W  (PULSE_W),
    .DIR_SETUP(DIR_SETUP),
    .CNT_W    (CNT_W)
  ) u_el (
    .clk       (clk4mhz),
    .reset_n   (reset_n),
    .cmd_active(el_act_r),
    .cmd_dir   (el_cdir_r),
    .cmd_fast  (el_cfast_r),
    .en_req    (trk_s),
    .step      (el_step),
    .dir       (el_dir),
    .en        (el_en)
  );

endmodule

// File: doc/gimbal_step_scheduler.md
Name: gimbal_step_scheduler

Overview:
Converts the per-field tracking decision into step/direction drive for two stepper axes, azimuth and elevation. The decision is the direction and speed bits that the target detector latches at end of active video, presented here with a one-cycle frame strobe. The block schedules the step pulses, enforces direction setup time, supports fast and slow rates, and parks both axes after the target is lost for several fields. It sits between the detector in the CPLD top level and the motor driver pins.

Parameters:
FAST_DIV, 4000, clk4mhz cycles between step rising edges at fast rate (1 kHz).
SLOW_DIV, 16000, cycles between step rising edges at slow rate (250 Hz).
PULSE_W, 8, step high time in cycles.
DIR_SETUP, 20, cycles that dir must be stable before a step rises.
LOST_FRAMES, 4, consecutive no-target fields before the axes park.
CNT_W, 16, width of the per-axis timing counters. Legality: FAST_DIV and SLOW_DIV must each be at least PULSE_W+2, and must fit in CNT_W bits.

Ports:
clk4mhz  in  1  system clock.
reset_n  in  1  asynchronous, active-low reset.
frame_valid  in  1  one-cycle strobe carrying a new field decision.
target_valid  in  1  a target was detected this field; sampled with frame_valid.
az_dir_in  in  1  azimuth direction request (1 = target left of centre).
el_dir_in  in  1  elevation direction request (1 = target above centre).
az_fast  in  1  azimuth uses FAST_DIV when 1, SLOW_DIV when 0.
el_fast  in  1  elevation uses FAST_DIV when 1, SLOW_DIV when 0.
az_hold  in  1  azimuth is inside the deadband; do not step. Sampled with frame_valid.
el_hold  in  1  elevation is inside the deadband; do not step. Sampled with frame_valid.
az_step  out  1  azimuth step pulse.
az_dir  out  1  azimuth direction to the driver.
az_en  out  1  azimuth driver enable.
el_step  out  1  elevation step pulse.
el_dir  out  1  elevation direction to the driver.
el_en  out  1  elevation driver enable.
tracking  out  1  high while not in the lost state.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - all outputs 0; both axis FSMs IDLE.
  - command registers cleared: active=0, dir=0, fast=0.
  - lost_cnt=LOST_FRAMES (saturated), so the block starts lost. Reset mid-pulse truncates the pulse immediately.
- Frame supervisor (acts only on the edge where frame_valid=1):
  - target_valid=1: lost_cnt<=0; tracking<=1. Per axis, cmd_active<=~hold, cmd_dir<=dir_in, cmd_fast<=fast.
  - target_valid=0: lost_cnt increments, saturating at LOST_FRAMES. Commands are held unchanged. When lost_cnt reaches LOST_FRAMES: tracking<=0 and cmd_active<=0 for both axes.
  - With frame_valid=0, all command and supervisor registers hold.
- Axis FSM (one instance per axis; states IDLE, SETUP, PULSE, GAP; one counter cnt of CNT_W bits):
  - IDLE: step=0.
    - cmd_active=1 and cmd_dir != dir: dir<=cmd_dir; cnt<=DIR_SETUP-1; go to SETUP.
    - cmd_active=1 and cmd_dir == dir: cnt<=PULSE_W-1; go to PULSE.
  - SETUP: decrement cnt. At cnt=0: cnt<=PULSE_W-1; go to PULSE.
  - PULSE: step=1; decrement cnt. At cnt=0: cnt<=period-PULSE_W-1, where period is chosen from cmd_fast at this edge; go to GAP.
  - GAP: step=0; decrement cnt. At cnt=0, re-evaluate exactly as in IDLE. If cmd_active=0, go to IDLE.
  - step is a registered output; it is high for exactly PULSE_W cycles.
  - With no direction change, the spacing between step rising edges is exactly period cycles.
- Command changes never truncate PULSE or GAP; new commands take effect at the next IDLE or GAP-end decision.
- A direction change always inserts SETUP. The dir output changes only on entry to SETUP, never while step=1.
- Enable: en=1 while tracking=1. After entering lost, en stays 1 until that axis is in IDLE, then drops to 0. It rises again on the edge where tracking rises.
- Latency: from the frame_valid edge, with the FSM in IDLE and no direction change, step rises 2 cycles later. With a direction change, add DIR_SETUP cycles.
- Simultaneous events:
  - frame_valid while an axis is in PULSE: the command latches, and the pulse completes unchanged.
  - frame_valid with target_valid=1 while in the lost state: recovery is immediate.

Test Plan:
Bench parameters: FAST_DIV=20, SLOW_DIV=50, PULSE_W=4, DIR_SETUP=6, LOST_FRAMES=3.
1. Release reset, then frame_valid with target=1, az_dir=0, az_fast=1, hold=0 → tracking and az_en rise next cycle; az_step rises 2 cycles after the strobe; pulses 4 cycles wide, every 20 cycles; el does the same.
2. While stepping fast, frame_valid with az_dir=1 → the current GAP completes; az_dir toggles at SETUP entry; the next az_step rises 6 cycles after the GAP ends; az_dir is stable throughout every pulse.
3. Change az_fast 1→0 at a frame strobe → the next GAP uses 46 cycles; the rising-edge spacing becomes 50 cycles.
4. Frame strobes with target_valid=0: the first two strobes leave stepping unchanged. The third strobe drops tracking; axes finish their current pulse/gap then go IDLE; az_en/el_en drop. A following strobe with target=1 restores stepping in 2 cycles.
5. el_hold=1 with target=1 → el_step stays 0, el_en=1, and az continues stepping.
6. Assert reset_n=0 mid-PULSE → az_step, az_dir, az_en, and tracking go to 0 immediately; after release, nothing steps until a target frame arrives.
